fp_add_arbiter: RTL

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter in front of a shared FP adder, one operation in flight at a time.
// Define FP_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with req[0] winning.
module fp_add_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] op_a0,
    input  logic [31:0] op_b0,
    input  logic [31:0] op_a1,
    input  logic [31:0] op_b1,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_status,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t     state_reg;
    logic       owner_reg;
    logic [7:0] count_reg;
    logic       winner;

`ifdef FP_ARB_ROUND_ROBIN_EN
    logic last_served_reg;

    // On a tie the requester that was not served last goes next.
    assign winner = (req == 2'b11) ? ~last_served_reg : ~req[0];
`else
    assign winner = ~req[0];
`endif

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            count_reg       <= 8'd0;
            gnt             <= 2'b00;
            rsp_valid       <= 2'b00;
            fpu_start       <= 1'b0;
            rsp_data        <= 32'd0;
            rsp_status      <= 4'd0;
            fpu_op_a        <= 32'd0;
            fpu_op_b        <= 32'd0;
`ifdef FP_ARB_ROUND_ROBIN_EN
            last_served_reg <= 1'b1;
`endif
        end else begin
            gnt       <= 2'b00;
            rsp_valid <= 2'b00;
            fpu_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // fpu_done arriving here belongs to no operation and is dropped.
                    if (req != 2'b00) begin
                        owner_reg <= winner;
                        fpu_op_a  <= winner ? op_a1 : op_a0;
                        fpu_op_b  <= winner ? op_b1 : op_b0;
                        gnt       <= winner ? 2'b10 : 2'b01;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_start <= 1'b1;
                    count_reg <= 8'(TIMEOUT_CYCLES);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // Completion is checked first so it wins over a same-cycle expiry.
                    if (fpu_done) begin
                        rsp_data   <= fpu_data;
                        rsp_status <= fpu_status;
                        rsp_valid  <= owner_reg ? 2'b10 : 2'b01;
                        count_reg  <= 8'd0;
                        state_reg  <= RESPOND;
                    end else if (count_reg <= 8'd1) begin
                        rsp_data   <= 32'd0;
                        rsp_status <= 4'hF;
                        rsp_valid  <= owner_reg ? 2'b10 : 2'b01;
                        count_reg  <= 8'd0;
                        state_reg  <= RESPOND;
                    end else begin
                        count_reg <= count_reg - 8'd1;
                    end
                end
                RESPOND: begin
`ifdef FP_ARB_ROUND_ROBIN_EN
                    last_served_reg <= owner_reg;
`endif
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
